// File: rtl/adder_32.sv
// Registered 32-bit adder: eight 4-bit carry-lookahead groups joined by a
// group-level lookahead unit, with the sum and carry-out captured one cycle later.
module adder_32 #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [WIDTH-1:0] input_a,
   input  logic [WIDTH-1:0] input_b,
   input  logic             cin,
   output logic [WIDTH-1:0] add_result,
   output logic             cout
);

   localparam int NGRP = WIDTH / GROUP;

   logic [WIDTH-1:0] p_s;
   logic [WIDTH-1:0] g_s;
   logic [WIDTH-1:0] sum_s;
   logic [NGRP-1:0]  grp_p_s;
   logic [NGRP-1:0]  grp_g_s;
   logic [NGRP-1:0]  grp_c_s;
   logic             cout_s;
   logic [WIDTH-1:0] add_result_r;
   logic             cout_r;

   // Group propagate/generate depend only on p/g, never on carries.
   function automatic logic [1:0] cla_group_pg(input logic [3:0] p, input logic [3:0] g);
      logic grp_g;
      logic grp_p;
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p;
      return {grp_g, grp_p};
   endfunction

   function automatic logic [3:0] cla_group_sum(input logic [3:0] p, input logic [3:0] g,
                                                input logic c0);
      logic [3:0] c;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      return p ^ c;
   endfunction

   assign p_s = input_a ^ input_b;
   assign g_s = input_a & input_b;

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      assign {grp_g_s[k], grp_p_s[k]} = cla_group_pg(p_s[k*GROUP +: GROUP], g_s[k*GROUP +: GROUP]);
      assign sum_s[k*GROUP +: GROUP]  = cla_group_sum(p_s[k*GROUP +: GROUP],
                                                      g_s[k*GROUP +: GROUP], grp_c_s[k]);
   end

   // Group-level lookahead: each group carry-in is a flat sum of products of G/P and cin.
   always_comb begin : grp_lookahead
      logic c_v;
      logic t_v;
      grp_c_s = {NGRP{1'b0}};
      c_v     = 1'b0;
      t_v     = 1'b0;
      for (int k = 0; k < NGRP; k++) begin
         c_v = cin;
         for (int j = 0; j < k; j++) begin
            c_v = c_v & grp_p_s[j];
         end
         for (int j = 0; j < k; j++) begin
            t_v = grp_g_s[j];
            for (int m = j + 1; m < k; m++) begin
               t_v = t_v & grp_p_s[m];
            end
            c_v = c_v | t_v;
         end
         grp_c_s[k] = c_v;
      end
   end

   assign cout_s = grp_g_s[NGRP-1] | (grp_p_s[NGRP-1] & grp_c_s[NGRP-1]);

   // Output capture; clear drops the outputs immediately and discards any in-flight sum.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         add_result_r <= {WIDTH{1'b0}};
         cout_r       <= 1'b0;
      end else begin
         add_result_r <= sum_s;
         cout_r       <= cout_s;
      end
   end

   assign add_result = add_result_r;
   assign cout       = cout_r;

endmodule

// File: tb/tb_adder_32.sv
// Directed and random-stream bench for adder_32, comparing {cout, add_result}
// against hand-computed values and a 33-bit reference sum.
module tb_adder_32;

   logic        clock;
   logic        clear;
   logic [31:0] input_a;
   logic [31:0] input_b;
   logic        cin;
   logic [31:0] add_result;
   logic        cout;

   int checks;
   int failures;

   adder_32 dut (
      .clock      (clock),
      .clear      (clear),
      .input_a    (input_a),
      .input_b    (input_b),
      .cin        (cin),
      .add_result (add_result),
      .cout       (cout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [32:0] got, input logic [32:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive at negedge, let one rising edge capture, compare at the next negedge.
   task automatic apply_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic c, input logic [32:0] exp);
      input_a = a;
      input_b = b;
      cin     = c;
      @(posedge clock);
      @(negedge clock);
      check_val(tag, {cout, add_result}, exp);
   endtask

   localparam int NVEC = 12;
   logic [31:0] va   [NVEC] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h0000000F, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                                32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'h0000FFFF};
   logic [31:0] vb   [NVEC] = '{32'h00000003, 32'h00000003, 32'h0000000A, 32'h0000000A,
                                32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000,
                                32'hFFFFFFFF, 32'h80000000, 32'h87654321, 32'h00000001};
   logic        vc   [NVEC] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b0};
   logic [32:0] vexp [NVEC] = '{33'h000000005, 33'h000000006, 33'h100000009, 33'h10000000A,
                                33'h000000010, 33'h080000000, 33'h100000000, 33'h000000000,
                                33'h1FFFFFFFF, 33'h100000000, 33'h099999999, 33'h000010000};

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic [32:0] rexp;
      checks   = 0;
      failures = 0;
      clear    = 1'b1;
      input_a  = 32'h00000002;
      input_b  = 32'h00000003;
      cin      = 1'b0;

      @(negedge clock);
      check_val("reset_state", {cout, add_result}, 33'h000000000);
      clear = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         apply_check($sformatf("vec%0d", i), va[i], vb[i], vc[i], vexp[i]);
      end

      // Outputs hold between edges even when operands change.
      input_a = 32'h00000007;
      input_b = 32'h00000007;
      #1;
      check_val("hold_between_edges", {cout, add_result}, 33'h000010000);

      apply_check("load_wrap", 32'hFFFFFFFF, 32'h0000000A, 1'b0, 33'h100000009);
      #2;
      clear = 1'b1;
      #1;
      check_val("clear_async", {cout, add_result}, 33'h000000000);
      input_a = 32'h00000002;
      input_b = 32'h00000003;
      cin     = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check_val("clear_held", {cout, add_result}, 33'h000000000);
      clear = 1'b0;
      #1;
      check_val("clear_release_no_stale", {cout, add_result}, 33'h000000000);
      @(posedge clock);
      @(negedge clock);
      check_val("first_after_clear", {cout, add_result}, 33'h000000005);

      for (int i = 0; i < 1000; i++) begin
         ra   = $urandom;
         rb   = $urandom;
         rc   = 1'($urandom_range(1, 0));
         rexp = {1'b0, ra} + {1'b0, rb} + {32'h00000000, rc};
         apply_check("rand", ra, rb, rc, rexp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adder_32.md
Name: adder_32

Overview:
- Registered 32-bit binary adder with carry-in and carry-out, used in the ALU datapath of the RISC CPU.
- Sum logic is a two-level carry-lookahead structure: eight 4-bit CLA groups plus a group-level lookahead unit.
- Result and carry-out are captured in output registers one clock after the operands are presented.
- An asynchronous active-high clear zeroes the output registers.

Parameters:
- WIDTH, 32, operand and result width. Fixed at 32; it must be a multiple of 4.
- GROUP, 4, bits per carry-lookahead group. Fixed at 4.

Ports:
- clock  input  1  single system clock; rising-edge active.
- clear  input  1  reset, asynchronous and active-high; forces the registered outputs to 0.
- input_a  input  32  operand A, unsigned/two's-complement agnostic.
- input_b  input  32  operand B.
- cin  input  1  carry-in, added at bit 0.
- add_result  output  32  registered sum bits [31:0] of input_a + input_b + cin.
- cout  output  1  registered carry out of bit 31.

Behaviour:
- Arithmetic: {cout, add_result} = input_a + input_b + cin, computed modulo 2^33. No saturation.
- No signed overflow flag; this is not reported.
- Per-bit signals: propagate p_i = a_i XOR b_i; generate g_i = a_i AND b_i.
- Each 4-bit group forms internal carries c1..c3 by lookahead from its group carry-in.
- Each group outputs sum s_i = p_i XOR c_i, a group propagate P and a group generate G.
- The group-level lookahead unit computes the eight group carry-ins from P/G and cin.
- cout = G7 OR (P7 AND c28).
- No ripple chain longer than 4 bits is permitted.
- Latency: exactly 1 cycle. Operands and cin sampled at rising edge N appear on add_result/cout after edge N and hold until the next edge.
- No handshake. A new operation is accepted every cycle (throughput 1/cycle).
- Inputs must be stable for setup before each rising edge. Combinational glitches are not visible at the outputs.
- Reset: clear=1 asynchronously forces add_result=32'h0 and cout=0 without waiting for a clock edge.
- Outputs stay 0 while clear is held. The first capture occurs on the first rising edge after clear deasserts.
- Clear asserted mid-operation discards the in-flight result; no stale value reappears after release.
- Clear and a rising edge at the same time: clear wins, outputs are 0.
- Wrap-around: an all-ones operand plus a nonzero value wraps add_result and sets cout=1.
- Boundary case: 32'hFFFFFFFF + 0 + cin=1 gives 0 with cout=1.
- Pure combinational X-free behaviour: for defined inputs, no X may propagate to the outputs.

Test Plan:
- input_a=2, input_b=3, cin=0, one clock -> add_result=32'h00000005, cout=0.
- input_a=2, input_b=3, cin=1, one clock -> add_result=32'h00000006, cout=0.
- input_a=32'hFFFFFFFF, input_b=10, cin=0 -> add_result=32'h00000009, cout=1.
- input_a=32'hFFFFFFFF, input_b=10, cin=1 -> add_result=32'h0000000A, cout=1.
- Carry-chain checks:
  - 32'h0000000F + 32'h00000001, cin=0 -> 32'h00000010, cout=0 (intra/inter-group carry).
  - 32'h7FFFFFFF + 1 -> 32'h80000000, cout=0.
  - 32'hFFFFFFFF + 0, cin=1 -> 0, cout=1.
- Reset:
  - Load 32'hFFFFFFFF+10; assert clear between clock edges -> outputs drop to 0 immediately and hold 0 while clear=1.
  - Release clear with operands 2+3 -> 5 appears after the next rising edge.
- Randomised stream: 1000 random operand/cin vectors, one per cycle -> each result matches the 33-bit reference sum one cycle later.
